pciecfg_mgmt_ctrl: RTL

Executes PCIe configuration-space requests against the 7-series PCIe core's cfg_mgmt port. It pops one request from the pciecfg request FIFO, runs the read or write handshake, and pushes one response of type FIFO_PCIECFG_T into the write side of the pciecfg out FIFO. It sits in the PCIe user-clock domain; the asynchronous FIFOs on either side carry traffic to and from the network side.

---
 rtl/pciecfg_pkg.sv | 29 ++
 rtl/pciecfg_mgmt_ctrl_if.sv | 31 +++
 rtl/pciecfg_timeout_cnt.sv | 35 +++
 rtl/pciecfg_mgmt_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pciecfg_pkg.sv
// ----------------------------------------------------------------------------
// pciecfg_pkg
// Shared types and constants for the PCIe configuration-management controller.
//   FIFO_PCIECFG_T          : request/response word carried by both FIFOs
//                             (MSB..LSB: tag, write, err, byte_en, dwaddr, data)
//   pciecfg_state_t         : controller state encoding
//   PCIECFG_TIMEOUT_DEFAULT : default done-wait budget in clock cycles
// ----------------------------------------------------------------------------
package pciecfg_pkg;

    localparam int PCIECFG_TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic [7:0]  tag;
        logic        write;
        logic        err;
        logic [3:0]  byte_en;
        logic [9:0]  dwaddr;
        logic [31:0] data;
    } FIFO_PCIECFG_T;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } pciecfg_state_t;

endpackage

// File: rtl/pciecfg_mgmt_ctrl_if.sv
// ----------------------------------------------------------------------------
// pciecfg_mgmt_ctrl_if
// Bundle of the 7-series PCIe core cfg_mgmt port.
//   master : the controller (drives address/data/enables, receives do/done)
//   slave  : the PCIe core side
// ----------------------------------------------------------------------------
interface pciecfg_mgmt_ctrl_if;
    logic [31:0] cfg_mgmt_do;
    logic        cfg_mgmt_rd_wr_done;
    logic [31:0] cfg_mgmt_di;
    logic [3:0]  cfg_mgmt_byte_en;
    logic [9:0]  cfg_mgmt_dwaddr;
    logic        cfg_mgmt_wr_en;
    logic        cfg_mgmt_rd_en;
    logic        cfg_mgmt_wr_readonly;
    logic        cfg_mgmt_wr_rw1c_as_rw;

    modport master (
        input  cfg_mgmt_do, cfg_mgmt_rd_wr_done,
        output cfg_mgmt_di, cfg_mgmt_byte_en, cfg_mgmt_dwaddr,
               cfg_mgmt_wr_en, cfg_mgmt_rd_en,
               cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw
    );

    modport slave (
        output cfg_mgmt_do, cfg_mgmt_rd_wr_done,
        input  cfg_mgmt_di, cfg_mgmt_byte_en, cfg_mgmt_dwaddr,
               cfg_mgmt_wr_en, cfg_mgmt_rd_en,
               cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw
    );
endinterface

// File: rtl/pciecfg_timeout_cnt.sv
// ----------------------------------------------------------------------------
// pciecfg_timeout_cnt
// 16-bit loadable down-counter; stops at zero.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over i_dec)
//   i_dec      : decrement by one
//   o_count    : current value
//   o_zero     : current value is zero
// ----------------------------------------------------------------------------
module pciecfg_timeout_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_dec,
    output logic [15:0] o_count,
    output logic        o_zero
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 16'd0);

endmodule

// File: rtl/pciecfg_mgmt_ctrl.sv
// ----------------------------------------------------------------------------
// pciecfg_mgmt_ctrl
// Pops one configuration request, runs the cfg_mgmt read/write handshake on
// the PCIe core and pushes exactly one response per request, in order.
//   clk, rst             : PCIe user clock, synchronous active-high reset
//   req_empty/rd_en/dout : request FIFO read side (standard, 1-cycle latency)
//   resp_full/wr_en/din  : response FIFO write side
//   TIMEOUT_CYCLES       : enable-high cycles before an access is aborted
//   cfg                  : cfg_mgmt bus (master side)
// Build option: define PCIECFG_WRITE_EN to allow configuration writes; when
// undefined, write requests are answered with err=1 without touching the core.
// ----------------------------------------------------------------------------
module pciecfg_mgmt_ctrl
    import pciecfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PCIECFG_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_empty,
    output logic                 req_rd_en,
    input  FIFO_PCIECFG_T        req_dout,
    input  logic                 resp_full,
    output logic                 resp_wr_en,
    output FIFO_PCIECFG_T        resp_din,
    pciecfg_mgmt_ctrl_if.master  cfg
);

    pciecfg_state_t r_state;
    logic [7:0]     r_tag;
    logic           r_write;
    logic [3:0]     r_be;
    logic [9:0]     r_addr;
    logic [31:0]    r_data;
    FIFO_PCIECFG_T  r_resp;
    logic           r_resp_wr_en;
    logic           r_rd_en;
`ifdef PCIECFG_WRITE_EN
    logic           r_wr_en;
`endif

    logic [15:0]    w_cnt;
    logic           w_cnt_zero;
    logic           w_expire;
    logic           w_done;
    logic [31:0]    w_rsp_data;
    logic           w_unused_err;

    // The incoming err bit has no meaning on a request.
    assign w_unused_err = req_dout.err;

    assign w_done = cfg.cfg_mgmt_rd_wr_done;

    // The counter is loaded with TIMEOUT_CYCLES on the first ISSUE cycle and
    // decremented each ISSUE cycle, so a value of 1 marks the last allowed
    // enable cycle; zero is only a guard against an out-of-range parameter.
    assign w_expire = (w_cnt == 16'd1) || w_cnt_zero;

    // Done wins over an expiring counter.
    assign w_rsp_data = w_done ? (r_write ? r_data : cfg.cfg_mgmt_do) : 32'd0;

    assign req_rd_en = (r_state == ST_IDLE) && !req_empty && !rst;

    pciecfg_timeout_cnt u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == ST_LATCH),
        .i_load_val (16'(TIMEOUT_CYCLES)),
        .i_dec      (r_state == ST_ISSUE),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // resp_wr_en is registered from resp_full of the previous cycle. This is
    // safe because the controller is the only writer of the response FIFO, so
    // full cannot rise between our sample and our push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tag        <= 8'd0;
            r_write      <= 1'b0;
            r_be         <= 4'd0;
            r_addr       <= 10'd0;
            r_data       <= 32'd0;
            r_resp       <= '0;
            r_resp_wr_en <= 1'b0;
            r_rd_en      <= 1'b0;
`ifdef PCIECFG_WRITE_EN
            r_wr_en      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_rd_en) begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_tag   <= req_dout.tag;
                    r_write <= req_dout.write;
                    r_be    <= req_dout.byte_en;
                    r_addr  <= req_dout.dwaddr;
                    r_data  <= req_dout.data;
                    if (!req_dout.write) begin
                        r_rd_en <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
`ifdef PCIECFG_WRITE_EN
                        r_wr_en <= 1'b1;
                        r_state <= ST_ISSUE;
`else
                        r_resp       <= {req_dout.tag, 1'b1, 1'b1, req_dout.byte_en,
                                         req_dout.dwaddr, 32'd0};
                        r_resp_wr_en <= !resp_full;
                        r_state      <= ST_RESP;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (w_done || w_expire) begin
                        r_rd_en      <= 1'b0;
`ifdef PCIECFG_WRITE_EN
                        r_wr_en      <= 1'b0;
`endif
                        r_resp       <= {r_tag, r_write, !w_done, r_be, r_addr, w_rsp_data};
                        r_resp_wr_en <= !resp_full;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_resp_wr_en) begin
                        r_resp_wr_en <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (!resp_full) begin
                        r_resp_wr_en <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_wr_en                 = r_resp_wr_en;
    assign resp_din                   = r_resp;
    assign cfg.cfg_mgmt_rd_en         = r_rd_en;
`ifdef PCIECFG_WRITE_EN
    assign cfg.cfg_mgmt_wr_en         = r_wr_en;
`else
    assign cfg.cfg_mgmt_wr_en         = 1'b0;
`endif
    assign cfg.cfg_mgmt_di            = r_data;
    assign cfg.cfg_mgmt_byte_en       = r_be;
    assign cfg.cfg_mgmt_dwaddr        = r_addr;
    assign cfg.cfg_mgmt_wr_readonly   = 1'b0;
    assign cfg.cfg_mgmt_wr_rw1c_as_rw = 1'b0;

endmodule
